// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped peripheral block.
// Holds the register address map, TCON bit positions, UART_CON bit
// positions and the UART transmitter state encoding.
package periph_pkg;

    localparam logic [31:0] PERIPH_BASE   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TH       = PERIPH_BASE + 32'h0000_0000;
    localparam logic [31:0] ADDR_TL       = PERIPH_BASE + 32'h0000_0004;
    localparam logic [31:0] ADDR_TCON     = PERIPH_BASE + 32'h0000_0008;
    localparam logic [31:0] ADDR_LED      = PERIPH_BASE + 32'h0000_000C;
    localparam logic [31:0] ADDR_SWITCH   = PERIPH_BASE + 32'h0000_0010;
    localparam logic [31:0] ADDR_DIGI     = PERIPH_BASE + 32'h0000_0014;
    localparam logic [31:0] ADDR_UART_TXD = PERIPH_BASE + 32'h0000_0018;
    localparam logic [31:0] ADDR_UART_CON = PERIPH_BASE + 32'h0000_0020;

    // TCON bit positions
    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    // UART_CON bit positions
    localparam int unsigned UCON_DONE = 0;
    localparam int unsigned UCON_BUSY = 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - begin a frame with data (ignored unless idle)
//   data[7:0]   - byte to send, captured on start
//   tx          - serial line, idle high (registered)
//   busy        - high in every state except idle
//   done_pulse  - single-cycle strobe during the last stop-bit cycle,
//                 so the caller can set its status flag on the same edge
//                 that returns the transmitter to idle
module uart_tx
    import periph_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done_pulse
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end_c;

    assign bit_end_c = (baud_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state and next-output logic; tx_d is the level for the next bit
    always_comb begin
        state_d    = state_q;
        baud_d     = bit_end_c ? '0 : baud_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_pulse = 1'b0;

        case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (start) begin
                    state_d = UART_START;
                    shift_d = data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (bit_end_c) begin
                    state_d = UART_DATA;
                    tx_d    = shift_q[0];
                end
            end
            UART_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            UART_STOP: begin
                if (bit_end_c) begin
                    state_d    = UART_IDLE;
                    tx_d       = 1'b1;
                    done_pulse = 1'b1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != UART_IDLE);

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral responder at 0x40000000.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   rd, wr        - CPU read / write strobes
//   addr, wdata   - CPU byte address and write data
//   rdata         - combinational read data, 0 when rd is low
//   switch        - board switch inputs
//   led           - board LEDs
//   digi          - 7-segment drive ([11:8] anodes, [7:0] segments)
//   irqout        - timer interrupt request (TCON irq enable & status)
//   tx            - UART serial output, idle high
module peripheral_bus
    import periph_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout,
    output logic        tx
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_done_q, tx_done_d;

    logic        uart_start_c;
    logic        uart_busy;
    logic        uart_done;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk        (clk),
        .reset      (reset),
        .start      (uart_start_c),
        .data       (txd_d),
        .tx         (tx),
        .busy       (uart_busy),
        .done_pulse (uart_done)
    );

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            txd_q     <= '0;
            tx_done_q <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;
        end
    end

    // Timer update, then CPU writes; later assignments give CPU writes priority
    always_comb begin
        th_d         = th_q;
        tl_d         = tl_q;
        tcon_d       = tcon_q;
        led_d        = led_q;
        digi_d       = digi_q;
        txd_d        = txd_q;
        tx_done_d    = tx_done_q;
        uart_start_c = 1'b0;

        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_IS] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wr) begin
            case (addr)
                ADDR_TH:   th_d   = wdata;
                ADDR_TL:   tl_d   = wdata;
                ADDR_TCON: tcon_d = wdata[2:0];
                ADDR_LED:  led_d  = wdata[7:0];
                ADDR_DIGI: digi_d = wdata[11:0];
                ADDR_UART_TXD: begin
                    // Writes while a frame is in flight are dropped
                    if (!uart_busy) begin
                        txd_d        = wdata[7:0];
                        uart_start_c = 1'b1;
                    end
                end
                ADDR_UART_CON: tx_done_d = wdata[UCON_DONE] & tx_done_q;
                default: ;
            endcase
        end

        if (uart_done) begin
            tx_done_d = 1'b1;
        end
    end

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (addr)
                ADDR_TH:       rdata = th_q;
                ADDR_TL:       rdata = tl_q;
                ADDR_TCON:     rdata = {29'd0, tcon_q};
                ADDR_LED:      rdata = {24'd0, led_q};
                ADDR_SWITCH:   rdata = {24'd0, switch};
                ADDR_DIGI:     rdata = {20'd0, digi_q};
                ADDR_UART_TXD: rdata = {24'd0, txd_q};
                ADDR_UART_CON: begin
                    rdata[UCON_DONE] = tx_done_q;
                    rdata[UCON_BUSY] = uart_busy;
                end
                default:       rdata = '0;
            endcase
        end
    end

    assign led    = led_q;
    assign digi   = digi_q;
    assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule
